// File: rtl/bp_nonsynth_cosim_arbiter_if.sv
// Commit-record bus between per-core commit taps and the shared checker port.
// master drives records/yumi (taps + checker side); slave is the arbiter.
interface bp_nonsynth_cosim_arbiter_if #(
    parameter int num_core_p     = 4,
    parameter int record_width_p = 128
);
    localparam int core_w_lp = (num_core_p > 1) ? $clog2(num_core_p) : 1;

    logic [num_core_p-1:0]                rec_v_i;
    logic [num_core_p*record_width_p-1:0] rec_data_i;
    logic [num_core_p-1:0]                rec_ready_o;
    logic                                 chk_v_o;
    logic [record_width_p-1:0]            chk_data_o;
    logic [core_w_lp-1:0]                 chk_core_o;
    logic                                 chk_yumi_i;

    modport master (
        output rec_v_i, rec_data_i, chk_yumi_i,
        input  rec_ready_o, chk_v_o, chk_data_o, chk_core_o
    );

    modport slave (
        input  rec_v_i, rec_data_i, chk_yumi_i,
        output rec_ready_o, chk_v_o, chk_data_o, chk_core_o
    );
endinterface

// File: rtl/bp_nonsynth_cosim_arbiter.sv
// Round-robin arbiter sharing one cosim checker port among per-core commit FIFOs.
// Ports: clk_i, reset_n_i (async low), en_i, freeze_i, finish_i, bus (slave:
// rec_v/rec_data/rec_ready, chk_v/chk_data/chk_core/chk_yumi), done_o,
// overrun_o, overrun_core_o, timeout_o. Optional stall watchdog: BP_COSIM_ARB_WATCHDOG_EN.
module bp_nonsynth_cosim_arbiter #(
    parameter int num_core_p     = 4,
    parameter int record_width_p = 128,
    parameter int lg_fifo_els_p  = 3,
    parameter int timeout_p      = 1024,
    localparam int core_w_lp     = (num_core_p > 1) ? $clog2(num_core_p) : 1
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  en_i,
    input  logic                  freeze_i,
    input  logic [num_core_p-1:0] finish_i,
    bp_nonsynth_cosim_arbiter_if.slave bus,
    output logic                  done_o,
    output logic                  overrun_o,
    output logic [core_w_lp-1:0]  overrun_core_o,
    output logic                  timeout_o
);
    localparam int els_lp = 1 << lg_fifo_els_p;
    localparam int lg_lp  = lg_fifo_els_p;

    if (num_core_p < 2 || lg_fifo_els_p < 1 || timeout_p < 1) begin : g_bad_cfg
        $error("bp_nonsynth_cosim_arbiter: bad parameters");
    end

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
    state_e state;

    logic [record_width_p-1:0] mem  [num_core_p][els_lp];
    logic [lg_lp:0]            wptr [num_core_p];
    logic [lg_lp:0]            rptr [num_core_p];

    logic [num_core_p-1:0] full, empty, enq, ovf, finished;
    logic [core_w_lp-1:0]  rr, gnt, ovf_core;
    logic                  gnt_v, active, out_v, deq_v;
    logic [lg_lp:0]        cnt;
    logic [core_w_lp:0]    sum;

    // Occupancy: difference of wrap-bit pointers; top bit set only when full.
    always_comb begin
        cnt   = '0;
        full  = '0;
        empty = '0;
        for (int i = 0; i < num_core_p; i++) begin
            cnt      = wptr[i] - rptr[i];
            full[i]  = cnt[lg_lp];
            empty[i] = (cnt == '0);
        end
    end

    assign bus.rec_ready_o = ~full & {num_core_p{state != DONE}};
    assign enq             = bus.rec_v_i & bus.rec_ready_o;
    assign ovf             = bus.rec_v_i & full & {num_core_p{state != DONE}};

    // First non-empty FIFO strictly after rr, wrapping.
    always_comb begin
        gnt_v = 1'b0;
        gnt   = '0;
        sum   = '0;
        for (int k = 1; k <= num_core_p; k++) begin
            sum = {1'b0, rr} + (core_w_lp+1)'(k);
            if (sum >= (core_w_lp+1)'(num_core_p))
                sum = sum - (core_w_lp+1)'(num_core_p);
            if (!gnt_v && !empty[sum[core_w_lp-1:0]]) begin
                gnt_v = 1'b1;
                gnt   = sum[core_w_lp-1:0];
            end
        end
    end

    // Lowest-index overrun wins.
    always_comb begin
        ovf_core = '0;
        for (int i = num_core_p - 1; i >= 0; i--)
            if (ovf[i]) ovf_core = core_w_lp'(i);
    end

    assign active         = (state == RUN) || (state == DRAIN);
    assign out_v          = active & ~freeze_i & gnt_v;
    assign deq_v          = out_v & bus.chk_yumi_i;
    assign bus.chk_v_o    = out_v;
    assign bus.chk_core_o = out_v ? gnt : '0;
    assign bus.chk_data_o = out_v ? mem[gnt][rptr[gnt][lg_lp-1:0]] : '0;

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < num_core_p; i++)
            if (enq[i])
                mem[i][wptr[i][lg_lp-1:0]] <=
                    bus.rec_data_i[i*record_width_p +: record_width_p];
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < num_core_p; i++) begin
                wptr[i] <= '0;
                rptr[i] <= '0;
            end
            rr <= core_w_lp'(num_core_p - 1);
        end else begin
            for (int i = 0; i < num_core_p; i++)
                if (enq[i]) wptr[i] <= wptr[i] + 1'b1;
            if (deq_v) begin
                rptr[gnt] <= rptr[gnt] + 1'b1;
                rr        <= gnt;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state          <= IDLE;
            finished       <= '0;
            done_o         <= 1'b0;
            overrun_o      <= 1'b0;
            overrun_core_o <= '0;
        end else begin
            finished <= finished | finish_i;
            if (!overrun_o && |ovf) begin
                overrun_o      <= 1'b1;
                overrun_core_o <= ovf_core;
            end
            unique case (state)
                IDLE:    if (en_i) state <= RUN;
                RUN:     if (&finished) state <= DRAIN;
                DRAIN: begin
                    // Occupancy is pre-dequeue, so the last yumi edge
                    // does not complete; DONE follows one cycle later.
                    if (&empty && ~|enq) begin
                        state  <= DONE;
                        done_o <= 1'b1;
                    end
                end
                DONE:    state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end

`ifndef SYNTHESIS
    yumi_legal_a: assert property (
        @(posedge clk_i) disable iff (!reset_n_i)
        bus.chk_yumi_i |-> bus.chk_v_o
    );
`endif

`ifdef BP_COSIM_ARB_WATCHDOG_EN
    localparam int wd_w_lp = $clog2(timeout_p + 1);
    logic [wd_w_lp-1:0] wd_cnt;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wd_cnt    <= '0;
            timeout_o <= 1'b0;
        end else if (!out_v || bus.chk_yumi_i) begin
            wd_cnt <= '0;
        end else if (wd_cnt != wd_w_lp'(timeout_p)) begin
            wd_cnt <= wd_cnt + 1'b1;
            if (wd_cnt == wd_w_lp'(timeout_p - 1) && !timeout_o) begin
                timeout_o <= 1'b1;
                $display("COSIM_ARB: checker stall, core %d", gnt);
            end
        end
    end
`else
    assign timeout_o = 1'b0;
`endif
endmodule

// File: tb/tb_bp_nonsynth_cosim_arbiter.sv
// Randomized scoreboard bench for bp_nonsynth_cosim_arbiter.
// Per-core model queues feed a monitor that checks every presented record.
module tb_bp_nonsynth_cosim_arbiter;
    localparam int N  = 4;
    localparam int W  = 128;
    localparam int LG = 3;
    localparam int D  = 8;
    localparam int TO = 16;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          freeze = 1'b0;
    logic [N-1:0]  finish = '0;
    logic          done, ovr, to;
    logic [CW-1:0] ovr_core;

    bp_nonsynth_cosim_arbiter_if #(.num_core_p(N), .record_width_p(W)) bus ();

    bp_nonsynth_cosim_arbiter #(
        .num_core_p(N), .record_width_p(W),
        .lg_fifo_els_p(LG), .timeout_p(TO)
    ) dut (
        .clk_i(clk), .reset_n_i(rst_n), .en_i(en), .freeze_i(freeze),
        .finish_i(finish), .bus(bus), .done_o(done), .overrun_o(ovr),
        .overrun_core_o(ovr_core), .timeout_o(to)
    );

    always #5 clk = ~clk;

    // Reference model: 0 idle, 1 run, 2 drain, 3 done
    logic [W-1:0] mq [N][$];
    int     mst, mptr, m_ovr_core, wd;
    bit     m_ovr, m_to, en_req;
    bit [N-1:0] m_fin;
    int     log_core[$];
    int     checks = 0;
    int     errors = 0;

    task automatic chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic int pick();
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (mptr + k) % N;
            if (mq[j].size() > 0) return j;
        end
        return -1;
    endfunction

    function automatic bit exp_valid();
        return (mst == 1 || mst == 2) && !freeze && pick() >= 0;
    endfunction

    // Monitor: two time units after the negedge, after yumi is settled.
    always @(negedge clk) begin
        #2;
        if (rst_n) begin
            int j;
            bit ev;
            ev = exp_valid();
            j  = pick();
            chk("chk_v", bus.chk_v_o, ev);
            if (ev) begin
                chk("chk_core", bus.chk_core_o, j);
                chk("chk_data", bus.chk_data_o, mq[j][0]);
                if (bus.chk_yumi_i) begin
                    void'(mq[j].pop_front());
                    mptr = j;
                    log_core.push_back(j);
                end
            end else begin
                chk("chk_data_idle", bus.chk_data_o, '0);
                chk("chk_core_idle", bus.chk_core_o, '0);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        en = 1'b0;
        freeze = 1'b0;
        finish = '0;
        bus.rec_v_i = '0;
        bus.chk_yumi_i = 1'b0;
        for (int i = 0; i < N; i++) mq[i].delete();
        log_core.delete();
        mst = 0; mptr = N - 1; m_fin = '0; m_ovr = 0; m_ovr_core = 0;
        m_to = 0; wd = 0; en_req = 0;
        #1;
        chk("rst_chk_v", bus.chk_v_o, 0);
        chk("rst_chk_data", bus.chk_data_o, 0);
        chk("rst_chk_core", bus.chk_core_o, 0);
        chk("rst_done", done, 0);
        chk("rst_ovr", ovr, 0);
        chk("rst_ovr_core", ovr_core, 0);
        chk("rst_timeout", to, 0);
        chk("rst_ready", bus.rec_ready_o, {N{1'b1}});
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic step(input logic [N-1:0] v, input logic [N-1:0] fin,
                        input bit frz, input int yp);
        logic [N-1:0] er, enq;
        bit pre_empty, ev, found;
        @(negedge clk);
        en = en_req;
        bus.rec_v_i = v;
        finish = fin;
        freeze = frz;
        for (int i = 0; i < N; i++)
            bus.rec_data_i[i*W +: W] = {$urandom(), $urandom(), $urandom(), $urandom()};
        #1;
        bus.chk_yumi_i = ($urandom_range(0, 99) < yp) && bus.chk_v_o;
        pre_empty = 1;
        for (int i = 0; i < N; i++) begin
            er[i] = (mst != 3) && mq[i].size() < D;
            if (mq[i].size() != 0) pre_empty = 0;
        end
        ev = exp_valid();
        chk("rec_ready", bus.rec_ready_o, er);
        chk("done", done, mst == 3);
        chk("overrun", ovr, m_ovr);
        chk("overrun_core", ovr_core, m_ovr_core);
        chk("timeout", to, m_to);
        #2;
        enq = (mst == 3) ? '0 : (v & er);
        for (int i = 0; i < N; i++)
            if (enq[i]) mq[i].push_back(bus.rec_data_i[i*W +: W]);
        found = 0;
        if (mst != 3 && !m_ovr)
            for (int i = 0; i < N; i++)
                if (!found && v[i] && !er[i]) begin
                    found = 1; m_ovr = 1; m_ovr_core = i;
                end
`ifdef BP_COSIM_ARB_WATCHDOG_EN
        if (ev && !bus.chk_yumi_i) begin
            wd++;
            if (wd >= TO) m_to = 1;
        end else begin
            wd = 0;
        end
`endif
        case (mst)
            0: if (en) mst = 1;
            1: if (&m_fin) mst = 2;
            2: if (pre_empty && enq == '0) mst = 3;
            default: ;
        endcase
        m_fin |= fin;
    endtask

    initial begin
        #200000;
        $display("FAIL sim_timeout reached without finishing");
        $fatal(1);
    end

    initial begin
        bus.rec_v_i = '0;
        bus.rec_data_i = '0;
        bus.chk_yumi_i = 1'b0;

        // Two cores enqueue together; core 0 first, then core 2
        do_reset();
        en_req = 1;
        step(4'b0101, '0, 0, 0);
        repeat (3) step('0, '0, 0, 100);
        chk("t1_len", log_core.size(), 2);
        chk("t1_first", log_core[0], 0);
        chk("t1_second", log_core[1], 2);

        // Continuous traffic, round-robin order
        do_reset();
        en_req = 1;
        repeat (7) step(4'hF, '0, 0, 100);
        chk("t2_len_ge6", log_core.size() >= 6, 1);
        for (int i = 0; i < 6; i++) chk("t2_rr_seq", log_core[i], i % N);

        // Overflow core 1
        do_reset();
        en_req = 1;
        repeat (9) step(4'b0010, '0, 0, 0);
        step('0, '0, 0, 0);
        chk("t3_ovr", ovr, 1);
        chk("t3_ovr_core", ovr_core, 1);
        chk("t3_ready1", bus.rec_ready_o[1], 0);

        // Freeze holds output; records keep order
        do_reset();
        en_req = 1;
        step(4'b0001, '0, 0, 0);
        step(4'b0001, '0, 0, 0);
        repeat (5) step('0, '0, 1, 100);
        chk("t4_frozen", log_core.size(), 0);
        repeat (3) step('0, '0, 0, 100);
        chk("t4_len", log_core.size(), 2);

        // Finish with records remaining, drain to done
        do_reset();
        en_req = 1;
        step(4'b0111, '0, 0, 0);
        step('0, 4'hF, 0, 100);
        for (int c = 0; c < 20 && !done; c++) step('0, '0, 0, 100);
        chk("t5_done", done, 1);
        repeat (3) step(4'hF, '0, 0, 100);
        chk("t5_ready_off", bus.rec_ready_o, '0);
        chk("t5_drained", log_core.size(), 3);

        // Randomized traffic, then drain
        do_reset();
        en_req = 0;
        repeat (3) step(N'($urandom_range(0, 15)), '0, 0, 70);
        en_req = 1;
        for (int c = 0; c < 400; c++)
            step(N'($urandom_range(0, 15)),
                 ($urandom_range(0, 99) < 2) ? N'(1 << $urandom_range(0, N-1)) : '0,
                 $urandom_range(0, 99) < 10, 70);
        step('0, 4'hF, 0, 100);
        for (int c = 0; c < 200 && !done; c++) step('0, '0, 0, 100);
        chk("t6_done", done, 1);

        // Watchdog
        do_reset();
        en_req = 1;
        step(4'b0001, '0, 0, 0);
        repeat (TO + 4) step('0, '0, 0, 0);
`ifdef BP_COSIM_ARB_WATCHDOG_EN
        chk("t7_wd_on", to, 1);
`else
        chk("t7_wd_off", to, 0);
`endif

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bp_nonsynth_cosim_arbiter.md
Name: bp_nonsynth_cosim_arbiter

Overview:
- Shares one co-simulation checker port among num_core_p per-core commit streams in multicore nonsynth testbenches.
- Buffers each core's commit records in a private FIFO and grants the checker round-robin, one record per cycle.
- Tracks per-core finish requests and reports global completion once every core is finished and drained.
- Sits between the per-core commit taps and the single checker/trace consumer.

Parameters:
- num_core_p, 4, number of requesting cores (2..16).
- record_width_p, 128, width of one commit record.
- lg_fifo_els_p, 3, log2 depth of each per-core FIFO (8 entries).
- timeout_p, 1024, watchdog stall limit in cycles (used only with the optional feature).

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous active-low reset.
- en_i  in  1  arbitration enable; leaves IDLE.
- freeze_i  in  1  holds output valid low while set; input buffering continues.
- rec_v_i  in  num_core_p  per-core record valid.
- rec_data_i  in  num_core_p*record_width_p  per-core records; core i at [i*record_width_p +: record_width_p].
- rec_ready_o  out  num_core_p  per-core FIFO not full.
- finish_i  in  num_core_p  per-core finish pulse; sticky internally.
- chk_v_o  out  1  record available to the checker.
- chk_data_o  out  record_width_p  granted record.
- chk_core_o  out  clog2(num_core_p), minimum 1  core id of the granted record.
- chk_yumi_i  in  1  checker consumes the record; legal only when chk_v_o=1.
- done_o  out  1  all cores finished and all FIFOs empty; sticky.
- overrun_o  out  1  sticky: enqueue attempted while that core's FIFO was full.
- overrun_core_o  out  clog2(num_core_p)  first core that overran.
- timeout_o  out  1  watchdog flag.

Behaviour:
- Reset (async assert, sync release): FIFOs empty, state IDLE, round-robin pointer = num_core_p-1 so core 0 wins first. Output reset values: chk_v_o=0, chk_data_o=0, chk_core_o=0, done_o=0, overrun_o=0, overrun_core_o=0, timeout_o=0. rec_ready_o reflects FIFO occupancy, so it is all-ones after reset.
- Enqueue: core i writes when rec_v_i[i] & rec_ready_o[i], in any state except DONE. Write at edge t; the record is visible at the FIFO head at t+1.
- Overrun: rec_v_i[i] & ~rec_ready_o[i] drops the record, sets overrun_o, and latches overrun_core_o. Only the first overrun is captured; on simultaneous overruns the lowest index wins.
- Grant: combinational. Candidates are the non-empty FIFOs; the grant goes to the first candidate strictly after the pointer, wrapping modulo num_core_p.
- Output: chk_v_o = (state RUN or DRAIN) & ~freeze_i & any candidate. chk_data_o and chk_core_o show the granted head; they read 0 when chk_v_o=0.
- Consume: on chk_yumi_i, dequeue the granted FIFO and set pointer = chk_core_o. Without yumi, neither grant nor pointer moves: a presented record stays stable until consumed.
- Simultaneous enqueue and dequeue on the same full FIFO is allowed. ready is computed from pre-dequeue occupancy, so rec_ready_o stays 0 that cycle; no bypass.
- Finish: finish_i[i] sets a sticky finished[i]; records arriving after finish are still accepted.
- FSM transitions:
  - IDLE -> RUN when en_i.
  - RUN -> DRAIN when finished is all-ones.
  - DRAIN -> DONE when all FIFOs are empty and no enqueue occurs this cycle.
  - DONE is terminal until reset. In DONE: done_o=1, chk_v_o=0, rec_ready_o=0.
  - en_i deassertion in RUN or DRAIN is ignored.
- chk_yumi_i while chk_v_o=0 is a protocol error: assertion fires, state unchanged.
- Reset mid-operation discards all buffered records and sticky flags.

Optional Feature:
- Macro BP_COSIM_ARB_WATCHDOG_EN.
- Defined: a counter clears on any cycle where chk_yumi_i=1 or chk_v_o=0. It increments while chk_v_o=1 & ~chk_yumi_i.
- Defined: when the counter reaches timeout_p, timeout_o is set (sticky until reset) and "COSIM_ARB: checker stall, core %d" is displayed once.
- Not defined: no counter is built and timeout_o is tied 0.

Test Plan:
- Reset, en_i=1, cores 0 and 2 each enqueue 1 record at the same edge, chk_yumi_i held 1 -> core 0 record consumed at t+1, core 2 at t+2, chk_v_o=0 at t+3.
- All 4 cores continuously valid, yumi every cycle -> chk_core_o sequence 0,1,2,3,0,1 with no repeats or skips.
- Core 1 enqueues 9 records with no yumi, depth 8 -> rec_ready_o[1]=0 after 8; 9th dropped; overrun_o=1, overrun_core_o=1.
- 2 records queued, freeze_i=1 for 5 cycles -> chk_v_o=0 throughout; after release both records emerge in order with unchanged data.
- finish_i pulsed on all cores while 3 records remain, yumi each cycle -> state DRAIN; done_o rises the cycle after the last yumi; later rec_v_i is ignored and rec_ready_o=0.
- Watchdog defined, timeout_p=16, one record held with chk_yumi_i=0 -> timeout_o=1 after exactly 16 stall cycles. Not defined -> timeout_o stays 0.
